// File: rtl/dac_pkg.sv
// Shared types and default sizing for the DAC sample pacer / linear interpolator.
package dac_pkg;

  localparam int DAC_DATA_WIDTH   = 32;
  localparam int DAC_FIFO_DEPTH   = 16;
  localparam int DAC_DIV_WIDTH    = 16;
  localparam int DAC_INTERP_SHIFT = 4;

  // Default-configuration widths of the interpolation accumulator and level counter.
  localparam int ACC_W = DAC_DATA_WIDTH + DAC_INTERP_SHIFT + 1;
  localparam int LVL_W = $clog2(DAC_FIFO_DEPTH) + 1;

  typedef logic signed [DAC_DATA_WIDTH-1:0] sample_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dac_sample_fifo.sv
// Sample FIFO with a first-word-fall-through head; pushes are dropped when full,
// pops are ignored when empty, and a simultaneous push+pop leaves the level unchanged.
module dac_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_en    = push_i && !full_o;
    rd_en    = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dac_sample_interp.sv
// Sample pacer and linear interpolator: releases one buffered sample per segment of
// 2^INTERP_SHIFT step ticks and ramps dac_data from the previous sample to the current one.
module dac_sample_interp
  import dac_pkg::*;
#(
  parameter int DATA_WIDTH   = DAC_DATA_WIDTH,
  parameter int FIFO_DEPTH   = DAC_FIFO_DEPTH,
  parameter int DIV_WIDTH    = DAC_DIV_WIDTH,
  parameter int INTERP_SHIFT = DAC_INTERP_SHIFT
) (
  input  logic                         clk_in,
  input  logic                         RST_n,
  input  logic                         enable,
  input  logic [DIV_WIDTH-1:0]         rate_div,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic signed [DATA_WIDTH-1:0] dac_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         underflow,
  input  logic                         clr_underflow
);

  localparam int ACC_BITS = DATA_WIDTH + INTERP_SHIFT + 1;
  localparam int DLT_BITS = DATA_WIDTH + 1;
  localparam int K_BITS   = (INTERP_SHIFT > 0) ? INTERP_SHIFT : 1;
  localparam logic [K_BITS-1:0] K_MAX = K_BITS'((1 << INTERP_SHIFT) - 1);

  state_t                       state_q, state_d;
  logic [DIV_WIDTH-1:0]         div_cnt_q, div_cnt_d;
  logic [K_BITS-1:0]            k_q, k_d;
  logic signed [ACC_BITS-1:0]   acc_q, acc_d;
  logic signed [DLT_BITS-1:0]   delta_q, delta_d;
  logic signed [DATA_WIDTH-1:0] cur_q, cur_d;
  logic signed [DATA_WIDTH-1:0] dac_q, dac_d;
  logic signed [DATA_WIDTH-1:0] head;
  logic                         underflow_q, underflow_d;
  logic                         tick, push, pop, full, empty;

  // Handshake: a sample transfers on a clock edge where s_valid && s_ready.
  assign s_ready    = RST_n && !full;
  assign push       = s_valid && s_ready;
  assign dac_data   = dac_q;
  assign underflow  = underflow_q;

  dac_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (RST_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (s_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_comb begin
    tick        = enable && (div_cnt_q == '0);
    div_cnt_d   = div_cnt_q;
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    delta_d     = delta_q;
    cur_d       = cur_q;
    pop         = 1'b0;
    underflow_d = underflow_q && !clr_underflow;

    if (enable) div_cnt_d = (div_cnt_q == '0) ? rate_div : div_cnt_q - 1'b1;

    if (tick) begin
      case (state_q)
        PRIME: begin
          if (!empty) begin
            pop     = 1'b1;
            cur_d   = head;
            acc_d   = ACC_BITS'(head) <<< INTERP_SHIFT;
            delta_d = '0;
            k_d     = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (k_q != K_MAX) begin
            acc_d = acc_q + ACC_BITS'(delta_q);
            k_d   = k_q + 1'b1;
          end else begin
            // Re-anchor on the exact sample so ramp rounding never accumulates.
            acc_d = ACC_BITS'(cur_q) <<< INTERP_SHIFT;
            k_d   = '0;
            if (!empty) begin
              pop     = 1'b1;
              delta_d = DLT_BITS'(head) - DLT_BITS'(cur_q);
              cur_d   = head;
            end else begin
              delta_d     = '0;
              underflow_d = 1'b1;
            end
          end
        end
        default: state_d = PRIME;
      endcase
    end

    dac_d = DATA_WIDTH'(acc_q >>> INTERP_SHIFT);
  end

  always_ff @(posedge clk_in or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= PRIME;
      div_cnt_q   <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      delta_q     <= '0;
      cur_q       <= '0;
      dac_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      delta_q     <= delta_d;
      cur_q       <= cur_d;
      dac_q       <= dac_d;
      underflow_q <= underflow_d;
    end
  end

endmodule
